imem_port_arbiter: RTL and testbench

Sequences and shares the single-ported, word-addressed instruction memory between the CPU fetch port and the program loader port. After reset it optionally zero-fills the memory, then admits only loader writes (BOOT) until the loader marks the last word. It then enters RUN, where fetch has priority and the loader is guaranteed a slot after a bounded wait. It sits between the fetch stage / loader and the instruction memory array, which has a synchronous 1-cycle read.

---
 rtl/imem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single-ported instruction memory between the CPU fetch port and
// the program loader. After reset the block optionally zero-fills the memory
// (ZERO), then accepts loader writes only (BOOT) until the loader flags its
// last word. From then on it runs in RUN, where fetch has priority and a
// waiting loader write is forced through after STARVE_LIMIT lost cycles.
// Optional feature macro: IMEM_ARB_ZERO_FILL_EN (enables the ZERO state).
module imem_port_arbiter #(
  parameter int MEM_DEPTH    = 1024,
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_valid,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_data,
  input  logic              l_last,
  output logic              l_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] ST_ZERO = 2'd0;
  localparam logic [1:0] ST_BOOT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

`ifdef IMEM_ARB_ZERO_FILL_EN
  localparam logic [1:0] ST_RESET = ST_ZERO;
`else
  localparam logic [1:0] ST_RESET = ST_BOOT;
`endif

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [7:0]        starve_reg;
  logic              err_reg;
  logic              f_rvalid_reg;
  logic [ADDR_W-1:0] f_idx;
  logic [ADDR_W-1:0] l_idx;
  logic              l_bad;

`ifdef IMEM_ARB_ZERO_FILL_EN
  logic [ADDR_W-1:0] zero_cnt_reg;
  logic              zero_done;
  assign zero_done = (zero_cnt_reg == ADDR_W'(MEM_DEPTH - 1));
`endif

  // Fetch address bits outside the word index are deliberately ignored.
  logic unused_f_addr_bits;
  assign unused_f_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0]};

  assign f_idx = f_addr[ADDR_W+1:2];
  assign l_idx = l_addr[ADDR_W+1:2];
  // A loader write is rejected from memory if misaligned or beyond the array.
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr[31:ADDR_W+2] != '0);

  assign busy     = (state_reg != ST_RUN);
  assign err      = err_reg;
  assign f_rvalid = f_rvalid_reg;
  assign f_rdata  = m_rdata;

  // Grant selection and memory port steering; everything is idle in reset.
  always_comb begin
    f_gnt   = 1'b0;
    l_ready = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (!reset) begin
      case (state_reg)
`ifdef IMEM_ARB_ZERO_FILL_EN
        ST_ZERO: begin
          m_en   = 1'b1;
          m_we   = 1'b1;
          m_addr = zero_cnt_reg;
        end
`endif
        ST_BOOT: l_ready = l_valid;
        ST_RUN: begin
          if (l_valid && (starve_reg == STARVE_MAX)) begin
            l_ready = 1'b1;
          end else if (f_req) begin
            f_gnt = 1'b1;
          end else begin
            l_ready = l_valid;
          end
        end
        default: ;
      endcase
      if (f_gnt) begin
        m_en   = 1'b1;
        m_addr = f_idx;
      end
      if (l_ready) begin
        m_en    = !l_bad;
        m_we    = !l_bad;
        m_addr  = l_idx;
        m_wdata = l_data;
      end
    end
  end

  // Phase sequencing: ZERO -> BOOT -> RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
`ifdef IMEM_ARB_ZERO_FILL_EN
      ST_ZERO: if (zero_done) state_next = ST_BOOT;
`endif
      ST_BOOT: if (l_ready && l_last) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RESET;
    endcase
  end

  // State, starvation counter, sticky error and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RESET;
      starve_reg   <= 8'd0;
      err_reg      <= 1'b0;
      f_rvalid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      f_rvalid_reg <= f_gnt;
      if (l_ready && l_bad) begin
        err_reg <= 1'b1;
      end
      if ((state_reg != ST_RUN) || l_ready) begin
        starve_reg <= 8'd0;
      end else if (l_valid && (starve_reg != STARVE_MAX)) begin
        starve_reg <= starve_reg + 8'd1;
      end
    end
  end

`ifdef IMEM_ARB_ZERO_FILL_EN
  // Zero-fill word counter, advancing once per ZERO cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_reg <= '0;
    end else if (state_reg == ST_ZERO) begin
      zero_cnt_reg <= zero_cnt_reg + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Drives random and directed fetch/loader traffic, models the memory array
// around the arbiter, and checks grants, memory port steering and fetch data
// against a word-map reference model. Honors IMEM_ARB_ZERO_FILL_EN.
module tb_imem_port_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int SL    = 8;
  localparam int PH_ZERO = 0;
  localparam int PH_BOOT = 1;
  localparam int PH_RUN  = 2;
`ifdef IMEM_ARB_ZERO_FILL_EN
  localparam int PH_RESET = PH_ZERO;
`else
  localparam int PH_RESET = PH_BOOT;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          l_valid = 1'b0;
  logic [31:0]   l_addr = '0;
  logic [31:0]   l_data = '0;
  logic          l_last = 1'b0;
  logic          l_ready;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;
  logic          busy;
  logic          err;

  imem_port_arbiter #(.MEM_DEPTH(DEPTH), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_last(l_last), .l_ready(l_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Instruction memory seen by the DUT: single port, 1-cycle registered read.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          phase = PH_RESET;
  int          zc = 0;
  int          starve = 0;
  bit          err_m = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model.
  task automatic cycle(input logic r, input logic fr, input logic [31:0] fa,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic ll);
    bit e_fg, e_lr, e_en, e_we, bad;
    int fidx, lidx;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    reset = r; f_req = fr; f_addr = fa; l_valid = lv; l_addr = la; l_data = ld; l_last = ll;
    #1;
    e_fg = 0; e_lr = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
    fidx = int'((fa / 4) % DEPTH);
    lidx = int'((la / 4) % DEPTH);
    bad  = (la % 4 != 0) || (la >= 32'(DEPTH * 4));
    if (!r) begin
      if (phase == PH_ZERO) begin
        e_en = 1; e_we = 1; e_addr = 32'(zc); e_wd = 0;
      end else if (phase == PH_BOOT) begin
        e_lr = lv;
      end else begin
        if (lv && starve == SL) e_lr = 1;
        else if (fr)            e_fg = 1;
        else                    e_lr = lv;
      end
      if (e_fg) begin
        e_en = 1; e_we = 0; e_addr = 32'(fidx);
      end
      if (e_lr) begin
        e_en = !bad; e_we = 1; e_addr = 32'(lidx); e_wd = ld;
      end
    end
    chk("f_gnt", 32'(f_gnt), 32'(e_fg));
    chk("l_ready", 32'(l_ready), 32'(e_lr));
    chk("m_en", 32'(m_en), 32'(e_en));
    chk("busy", 32'(busy), 32'(phase != PH_RUN));
    chk("err", 32'(err), 32'(err_m));
    if (e_en) begin
      chk("m_we", 32'(m_we), 32'(e_we));
      chk("m_addr", 32'(m_addr), e_addr);
      if (e_we) chk("m_wdata", m_wdata, e_wd);
    end
    if (e_fg) $display("fetch  addr=%h word=%0d", fa, fidx);
    if (e_lr) $display("load   addr=%h data=%h last=%0b bad=%0b", la, ld, ll, bad);
    if (r) begin
      phase = PH_RESET; zc = 0; starve = 0; err_m = 0;
    end else begin
      if (e_fg) exp_q.push_back(ref_mem[fidx]);
      if (e_lr && !bad) ref_mem[lidx] = ld;
      if (e_lr && bad)  err_m = 1;
      if (phase == PH_ZERO) begin
        ref_mem[zc] = 0;
        zc++;
        if (zc == DEPTH) phase = PH_BOOT;
      end else if (phase == PH_BOOT) begin
        starve = 0;
        if (e_lr && ll) phase = PH_RUN;
      end else begin
        if (e_lr)    starve = 0;
        else if (lv) starve = (starve < SL) ? starve + 1 : SL;
      end
    end
  endtask

  // Monitor: every grant must be answered by f_rvalid on the next cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("f_rvalid_idle", 32'(f_rvalid), 32'd0);
      end else begin
        chk("f_rvalid", 32'(f_rvalid), 32'd1);
        chk("f_rdata", f_rdata, exp_q.pop_front());
        $display("rdata  %h", f_rdata);
      end
    end
  end

  initial begin
    logic [31:0] fa, la;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
      ref_mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
    end

    // Reset held: outputs idle.
    repeat (3) cycle(1, 1, 32'h8, 1, 32'h0, 32'h1, 0);

`ifdef IMEM_ARB_ZERO_FILL_EN
    // Zero fill with fetch and loader requests pending (both must be ignored).
    repeat (DEPTH) cycle(0, 1, 32'h4, 1, 32'h0, 32'hFFFF_FFFF, 0);
`endif

    // Boot load with fetch held high; fetch must not be granted before RUN.
    cycle(0, 1, 32'h8, 1, 32'h0, 32'h0050_0093, 0);
    cycle(0, 1, 32'h8, 1, 32'h4, 32'h0010_0113, 0);
    cycle(0, 1, 32'h8, 1, 32'h8, 32'h0020_81B3, 1);
    cycle(0, 1, 32'h8, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, 32'h4, 0, 32'h0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Bad loader addresses: accepted, not written, err sticks.
    cycle(0, 0, 32'h0, 1, 32'h6, 32'hDEAD_BEEF, 0);
    cycle(0, 0, 32'h0, 1, 32'h1000, 32'hCAFE_F00D, 0);
    cycle(0, 1, 32'h0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, 32'h4, 0, 32'h0, 32'h0, 0);

    // Write then immediate read of the same word.
    cycle(0, 0, 32'h0, 1, 32'h10, 32'hA5A5_0001, 0);
    cycle(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);

    // Starvation: fetch and loader both held.
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 32'($urandom_range(0, 63)) << 2, 1, 32'($urandom_range(0, 63)) << 2, $urandom, 0);
    end

    // Reset in the middle of BOOT after two writes.
    cycle(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
`ifdef IMEM_ARB_ZERO_FILL_EN
    repeat (DEPTH) cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
`endif
    cycle(0, 1, 32'h0, 1, 32'h20, 32'h1111_1111, 0);
    cycle(0, 1, 32'h0, 1, 32'h24, 32'h2222_2222, 0);
    cycle(1, 1, 32'h0, 1, 32'h28, 32'h3333_3333, 1);
    cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Random traffic, with occasional resets and bad loader addresses.
    for (int i = 0; i < 1500; i++) begin
      fa = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) la = $urandom;
      else la = 32'($urandom_range(0, 63)) << 2;
      cycle(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), fa,
            ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, la, $urandom,
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
